// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences RV32I trap entry and mret, owns mstatus.MIE/MPIE
module trap_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_tval,
   input  logic [XLEN-1:0] pc_cur,
   input  logic [XLEN-1:0] pc_next,
   input  logic            instr_done,
   input  logic [2:0]      irq,
   input  logic            mret,
   input  logic            csr_we,
   input  logic            csr_mie_d,
   input  logic            csr_mpie_d,
   output logic            busy,
   output logic            flush,
   output logic            mepc_ld,
   output logic [XLEN-1:0] mepc_d,
   output logic            mcause_ld,
   output logic [XLEN-1:0] mcause_d,
   output logic            mtval_ld,
   output logic [XLEN-1:0] mtval_d,
   output logic            pc_ld,
   output logic            pc_sel,
   output logic            mie,
   output logic            mpie
);
   typedef enum logic [1:0] {IDLE, SAVE, VECTOR, RET} state_t;
   state_t state, state_n;
   logic idle, take_exc, take_irq, take_ret;
   logic [3:0] irq_code;
   // acceptance arbitration in IDLE and next-state selection
   always_comb begin
      idle = state == IDLE;
      take_exc = idle && exc_valid;
      take_irq = idle && !exc_valid && instr_done && mie && (irq != 3'b000);
      take_ret = idle && !exc_valid && !take_irq && mret;
      irq_code = irq[2] ? 4'd11 : irq[1] ? 4'd3 : 4'd7;
      state_n = (take_exc || take_irq) ? SAVE : take_ret ? RET : (state == SAVE) ? VECTOR : IDLE;
   end
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   // capture trap data on acceptance, hold it otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mepc_d <= '0;
         mcause_d <= '0;
         mtval_d <= '0;
      end else if (take_exc) begin
         mepc_d <= pc_cur;
         mcause_d <= {{(XLEN-4){1'b0}}, exc_cause};
         mtval_d <= exc_tval;
      end else if (take_irq) begin
         mepc_d <= pc_next;
         mcause_d <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
         mtval_d <= '0;
      end
   end
   // mstatus interrupt-enable stack; a request in the same cycle drops the csr write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie <= 1'b0;
         mpie <= 1'b0;
      end else if (state == SAVE) begin
         mpie <= mie;
         mie <= 1'b0;
      end else if (state == RET) begin
         mie <= mpie;
         mpie <= 1'b1;
      end else if (idle && csr_we && !take_exc && !take_irq && !take_ret) begin
         mie <= csr_mie_d;
         mpie <= csr_mpie_d;
      end
   end
   assign busy = !idle;
   assign flush = !idle;
   assign mepc_ld = state == SAVE;
   assign mcause_ld = state == SAVE;
   assign mtval_ld = state == SAVE;
   assign pc_ld = (state == VECTOR) || (state == RET);
   assign pc_sel = state == RET;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench with a transaction-level model of the trap sequencer
module tb_trap_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   logic exc_valid = 0, instr_done = 0, mret = 0, csr_we = 0, csr_mie_d = 0, csr_mpie_d = 0;
   logic [3:0] exc_cause = 0;
   logic [31:0] exc_tval = 0, pc_cur = 0, pc_next = 0;
   logic [2:0] irq = 0;
   logic busy, flush, mepc_ld, mcause_ld, mtval_ld, pc_ld, pc_sel, mie, mpie;
   logic [31:0] mepc_d, mcause_d, mtval_d;

   trap_sequencer #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
      .pc_cur(pc_cur), .pc_next(pc_next), .instr_done(instr_done), .irq(irq), .mret(mret),
      .csr_we(csr_we), .csr_mie_d(csr_mie_d), .csr_mpie_d(csr_mpie_d), .busy(busy), .flush(flush),
      .mepc_ld(mepc_ld), .mepc_d(mepc_d), .mcause_ld(mcause_ld), .mcause_d(mcause_d),
      .mtval_ld(mtval_ld), .mtval_d(mtval_d), .pc_ld(pc_ld), .pc_sel(pc_sel), .mie(mie), .mpie(mpie)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ret;
      logic [31:0] mepc, mcause, mtval;
      logic emie, empie;
   } exp_t;
   exp_t q[$];
   exp_t mon_e, vexp, rexp;
   logic vec_pend = 0, ret_pend = 0;
   int n_cmp = 0, n_fail = 0;
   logic m_mie = 0, m_mpie = 0;
   int blk = 0;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] b);
      n_cmp++;
      if (a !== b) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, b, $time);
      end
   endtask

   // one clock of stimulus; the model tracks acceptance, busy time and the MIE/MPIE stack
   task automatic step(input logic ev, input logic [3:0] ec, input logic [31:0] et, input logic [31:0] pcc,
                       input logic [31:0] pcn, input logic ido, input logic [2:0] ir, input logic mr,
                       input logic cw, input logic cm, input logic cp);
      exp_t e;
      int nb;
      @(posedge clk);
      #1;
      chk("busy", busy, blk > 0);
      chk("flush", flush, blk > 0);
      if (blk == 0) begin
         chk("mie_idle", mie, m_mie);
         chk("mpie_idle", mpie, m_mpie);
      end
      exc_valid = ev; exc_cause = ec; exc_tval = et; pc_cur = pcc; pc_next = pcn;
      instr_done = ido; irq = ir; mret = mr; csr_we = cw; csr_mie_d = cm; csr_mpie_d = cp;
      nb = blk > 0 ? blk - 1 : 0;
      if (blk == 0) begin
         if (ev) begin
            e = '{1'b0, pcc, {28'd0, ec}, et, 1'b0, m_mie};
            q.push_back(e);
            m_mpie = m_mie; m_mie = 0; nb = 2;
         end else if (ido && m_mie && ir != 0) begin
            e = '{1'b0, pcn, ir[2] ? 32'h8000000B : ir[1] ? 32'h80000003 : 32'h80000007, 32'd0, 1'b0, m_mie};
            q.push_back(e);
            m_mpie = m_mie; m_mie = 0; nb = 2;
         end else if (mr) begin
            e = '{1'b1, 32'd0, 32'd0, 32'd0, m_mpie, 1'b1};
            q.push_back(e);
            m_mie = m_mpie; m_mpie = 1; nb = 1;
         end else if (cw) begin
            m_mie = cm; m_mpie = cp;
         end
      end
      blk = nb;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic set_mie(input logic v);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, v, 0);
   endtask

   // monitor: consumes expected transactions whenever the DUT strobes
   always @(negedge clk) begin
      if (mepc_ld) begin
         if (q.size() == 0) chk("unexpected_save", 1, 0);
         else begin
            mon_e = q.pop_front();
            chk("save_kind", {31'd0, mon_e.ret}, 0);
            chk("mepc_d", mepc_d, mon_e.mepc);
            chk("mcause_d", mcause_d, mon_e.mcause);
            chk("mtval_d", mtval_d, mon_e.mtval);
            chk("save_strobes", {28'd0, mcause_ld, mtval_ld, flush, pc_ld}, 32'hE);
            vexp = mon_e;
            vec_pend = 1;
         end
      end else if (pc_ld) begin
         if (vec_pend) begin
            chk("vec_pc_sel", pc_sel, 0);
            chk("vec_mie", mie, vexp.emie);
            chk("vec_mpie", mpie, vexp.empie);
            vec_pend = 0;
         end else if (q.size() == 0) chk("unexpected_pc_ld", 1, 0);
         else begin
            mon_e = q.pop_front();
            chk("ret_kind", {31'd0, mon_e.ret}, 1);
            chk("ret_pc_sel", pc_sel, 1);
            chk("ret_flush", flush, 1);
            rexp = mon_e;
            ret_pend = 1;
         end
      end else begin
         if (vec_pend) chk("missing_vector", 0, 1);
         vec_pend = 0;
         if (ret_pend) begin
            chk("ret_mie", mie, rexp.emie);
            chk("ret_mpie", mpie, rexp.empie);
         end
         ret_pend = 0;
      end
   end

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {27'd0, mepc_ld, mcause_ld, mtval_ld, pc_ld, pc_sel}, 0);
      chk("rst_mie", {30'd0, mie, mpie}, 0);
      chk("rst_data", mepc_d | mcause_d | mtval_d, 0);
      @(posedge clk); #1; rst = 0;
      set_mie(1);
      step(1, 4'd2, 32'h13, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      set_mie(1);
      step(0, 0, 0, 0, 32'h204, 1, 3'b111, 0, 0, 0, 0);
      idle(3);
      set_mie(1);
      step(0, 0, 0, 0, 32'h208, 1, 3'b011, 0, 0, 0, 0);
      idle(3);
      set_mie(1);
      step(0, 0, 0, 0, 32'h20C, 1, 3'b001, 0, 0, 0, 0);
      idle(3);
      set_mie(1);
      step(1, 4'd7, 32'hDEAD, 32'h300, 32'h304, 1, 3'b111, 1, 0, 0, 0);
      idle(3);
      set_mie(0);
      repeat (10) step(0, 0, 0, 0, 32'h400, 1, 3'b100, 0, 0, 0, 0);
      set_mie(1);
      repeat (5) step(0, 0, 0, 0, 32'h400, 0, 3'b111, 0, 0, 0, 0);
      step(1, 4'd11, 32'h55, 32'h500, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(3);
      step(1, 4'd4, 32'h77, 32'h600, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 1;
      exc_valid = 0;
      #1;
      chk("midrst_strobes", {27'd0, mepc_ld, mcause_ld, mtval_ld, pc_ld, flush}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mie", {30'd0, mie, mpie}, 0);
      chk("midrst_data", mepc_d | mcause_d | mtval_d, 0);
      q.delete();
      blk = 0; m_mie = 0; m_mpie = 0;
      @(posedge clk); #1; rst = 0;
      idle(6);
      step(1, 4'd4, 32'h77, 32'h600, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(5) == 0, 4'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
              $urandom_range(3) == 0 ? 3'($urandom) : 3'd0, $urandom_range(5) == 0,
              $urandom_range(4) == 0, 1'($urandom), 1'($urandom));
      idle(5);
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle controller that sequences trap entry and `mret` for the RV32I trap datapath.
- Arbitrates between synchronous exceptions, three machine interrupt lines and `mret`.
- Drives the load strobes and data for the external mepc/mcause/mtval/PC registers, and the PC source select.
- Owns mstatus.MIE/MPIE internally. Sits between the decode/exception logic and the CSR/PC registers.

Parameters:
XLEN, 32, datapath width for PC, tval and CSR data.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
exc_valid  in  1  synchronous exception present this cycle
exc_cause  in  4  exception code (0..15)
exc_tval  in  XLEN  faulting address/instruction for mtval
pc_cur  in  XLEN  PC of the current (faulting) instruction
pc_next  in  XLEN  PC of the next instruction to execute (interrupt return point)
instr_done  in  1  current instruction retires this cycle (interrupt boundary)
irq  in  3  pending interrupts: [2]=MEI, [1]=MSI, [0]=MTI
mret  in  1  `mret` decoded and retiring this cycle
csr_we  in  1  software write of mstatus MIE/MPIE
csr_mie_d  in  1  new MIE value
csr_mpie_d  in  1  new MPIE value
busy  out  1  sequence in progress; the pipeline must hold
flush  out  1  kill in-flight instruction
mepc_ld  out  1  load strobe for mepc
mepc_d  out  XLEN  mepc data
mcause_ld  out  1  load strobe for mcause
mcause_d  out  XLEN  mcause data
mtval_ld  out  1  load strobe for mtval
mtval_d  out  XLEN  mtval data
pc_ld  out  1  load strobe for PC
pc_sel  out  1  PC source: 0=mtvec, 1=mepc
mie  out  1  mstatus.MIE
mpie  out  1  mstatus.MPIE

Behaviour:
- Reset (async, immediate):
  - State IDLE; mie=0, mpie=0.
  - All strobes, flush and busy are 0; pc_sel=0.
  - Latched data registers are 0; mepc_d/mcause_d/mtval_d read 0.
- States:
  - IDLE: no strobes.
  - SAVE: mepc_ld=mcause_ld=mtval_ld=1, flush=1, busy=1.
  - VECTOR: pc_ld=1, pc_sel=0, flush=1, busy=1.
  - RET: pc_ld=1, pc_sel=1, flush=1, busy=1.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Acceptance in IDLE, evaluated each cycle, with fixed priority:
  1. exc_valid.
  2. Interrupt: requires instr_done=1, mie=1 and irq!=0. Among interrupts MEI > MSI > MTI.
  3. mret.
- Exception accepted:
  - Latch mepc_d=pc_cur, mcause_d={0, 27'b0, exc_cause}, mtval_d=exc_tval.
  - Next state SAVE.
- Interrupt accepted:
  - Latch mepc_d=pc_next, mtval_d=0.
  - mcause_d = 0x8000000B (MEI), 0x80000003 (MSI) or 0x80000007 (MTI).
  - Next state SAVE.
- SAVE -> VECTOR unconditionally, one cycle later.
  - On the SAVE->VECTOR edge: mpie<=mie, mie<=0.
- VECTOR -> IDLE unconditionally.
- Trap latency: request cycle N; strobes in N+1; PC load in N+2; IDLE again in N+3. The earliest next acceptance is N+3.
- mret accepted: next state RET.
  - RET -> IDLE unconditionally.
  - On the RET->IDLE edge: mie<=mpie, mpie<=1.
- In SAVE/VECTOR/RET all requests are ignored, not queued. Sources must hold or re-present them.
- mepc_d/mcause_d/mtval_d hold their last latched value outside SAVE.
- CSR writes:
  - csr_we applies in IDLE only, when no request is accepted that cycle: mie<=csr_mie_d, mpie<=csr_mpie_d.
  - If a trap or mret is accepted in the same cycle, the trap/mret wins and the write is dropped.
  - csr_we is ignored outside IDLE.
- Interrupt gating:
  - mie is sampled as the registered value. A csr_we setting MIE does not enable an interrupt in the same cycle.
  - irq with mie=0 is never accepted.
- Reset asserted mid-sequence aborts at once. No partial strobes after rst deasserts.

Test Plan:
- Reset, then exc_valid=1, cause=2, tval=0x00000013, pc_cur=0x100 for one cycle (mie=1):
  - Next cycle: mepc_ld/mcause_ld/mtval_ld=1, mepc_d=0x100, mcause_d=0x2, mtval_d=0x13.
  - Following cycle: pc_ld=1, pc_sel=0, mie=0, mpie=1.
  - busy high exactly 2 cycles.
- csr_we with mie=1; then irq=3'b111 + instr_done, pc_next=0x204:
  - mcause_d=0x8000000B, mepc_d=0x204, mtval_d=0.
  - Repeat with irq=3'b011: mcause_d=0x80000003. With irq=3'b001: mcause_d=0x80000007.
- exc_valid, irq and mret asserted together in IDLE with mie=1 -> exception path taken; irq and mret dropped.
- irq=3'b100 with mie=0 for 10 cycles -> no strobes. irq with mie=1 but instr_done=0 -> no acceptance.
- After a trap (mie=0, mpie=1), assert mret:
  - Next cycle: pc_ld=1, pc_sel=1, flush=1.
  - Then mie=1, mpie=1, state IDLE.
  - csr_we in the same cycle as mret is dropped.
- Assert rst during SAVE -> all strobes 0 immediately, mie=0.
  - After release, no pc_ld occurs without a new request.
  - Re-present the exception -> normal 3-cycle sequence.
